// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared word width, FSM state codes and port IDs for the word-store arbiter
package mem_arbiter_pkg;

  // Store word width shared by the CPU and console paths.
  localparam int WORD = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin front end for the 16-bit word store
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata     port A (CPU) request, held until a_ack
//   a_ack/a_rdata                 port A one-cycle completion and read data
//   b_*                           port B (console loader), same set as port A
//   err                           pulses with the ack of an access that timed out
//   m_addr/m_d/m_rd/m_wr          store address, write data and strobes
//   m_q/m_wait                    store read data (cycle after accept) and stall
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ABITS   = 9,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [ABITS-1:0] a_addr,
  input  logic [WORD-1:0]  a_wdata,
  output logic             a_ack,
  output logic [WORD-1:0]  a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [ABITS-1:0] b_addr,
  input  logic [WORD-1:0]  b_wdata,
  output logic             b_ack,
  output logic [WORD-1:0]  b_rdata,
  output logic             err,
  output logic [ABITS-1:0] m_addr,
  output logic [WORD-1:0]  m_d,
  output logic             m_rd,
  output logic             m_wr,
  input  logic [WORD-1:0]  m_q,
  input  logic             m_wait
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t             state, state_n;
  port_t              last, last_n;
  port_t              gnt, gnt_n;
  logic               we_l, we_n;
  logic [ABITS-1:0]   addr_l, addr_n;
  logic [WORD-1:0]    wdata_l, wdata_n;
  logic [7:0]         wcnt, wcnt_n;
  logic [7:0]         wcnt_inc;
  logic               abort, abort_n;

  // Round-robin pick: a lone requester always wins; on a tie the master
  // that was not served last goes first.
  function automatic port_t rr_pick(input logic a, input logic b, input port_t prev);
    if (a && b) begin
      return (prev == PORT_A) ? PORT_B : PORT_A;
    end else if (a) begin
      return PORT_A;
    end else begin
      return PORT_B;
    end
  endfunction

  assign wcnt_inc = wcnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      last    <= PORT_B;
      gnt     <= PORT_A;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      wcnt    <= '0;
      abort   <= 1'b0;
    end else begin
      state   <= state_n;
      last    <= last_n;
      gnt     <= gnt_n;
      we_l    <= we_n;
      addr_l  <= addr_n;
      wdata_l <= wdata_n;
      wcnt    <= wcnt_n;
      abort   <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    gnt_n   = gnt;
    we_n    = we_l;
    addr_n  = addr_l;
    wdata_n = wdata_l;
    wcnt_n  = wcnt;
    abort_n = abort;
    case (state)
      S_IDLE: begin
        if (a_req || b_req) begin
          gnt_n   = rr_pick(a_req, b_req, last);
          last_n  = gnt_n;
          we_n    = (gnt_n == PORT_A) ? a_we    : b_we;
          addr_n  = (gnt_n == PORT_A) ? a_addr  : b_addr;
          wdata_n = (gnt_n == PORT_A) ? a_wdata : b_wdata;
          wcnt_n  = '0;
          abort_n = 1'b0;
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!m_wait) begin
          wcnt_n  = '0;
          state_n = S_DONE;
        end else if (wcnt_inc == TO) begin
          // Store has stalled too long: give up and report it with the ack.
          wcnt_n  = '0;
          abort_n = 1'b1;
          state_n = S_DONE;
        end else begin
          wcnt_n = wcnt_inc;
        end
      end
      S_DONE: begin
        abort_n = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs decode purely from registered state, so reset clears them at once.
  always_comb begin
    m_addr  = addr_l;
    m_d     = wdata_l;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    a_ack   = 1'b0;
    b_ack   = 1'b0;
    a_rdata = '0;
    b_rdata = '0;
    err     = 1'b0;
    if (state == S_ACCESS) begin
      m_rd = !we_l;
      m_wr = we_l;
    end
    if (state == S_DONE) begin
      err = abort;
      if (gnt == PORT_A) begin
        a_ack = 1'b1;
      end else begin
        b_ack = 1'b1;
      end
      // Read data flows straight from the store during the ack cycle.
      if (!we_l && !abort) begin
        if (gnt == PORT_A) begin
          a_rdata = m_q;
        end else begin
          b_rdata = m_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a word-store model
module tb_mem_arbiter;

  localparam int ABITS   = 9;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_req, a_we, b_req, b_we;
  logic [ABITS-1:0] a_addr, b_addr;
  logic [15:0]      a_wdata, b_wdata;
  logic             a_ack, b_ack, err;
  logic [15:0]      a_rdata, b_rdata;
  logic [ABITS-1:0] m_addr;
  logic [15:0]      m_d, m_q;
  logic             m_rd, m_wr, m_wait;

  mem_arbiter #(.ABITS(ABITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .err(err),
    .m_addr(m_addr), .m_d(m_d), .m_rd(m_rd), .m_wr(m_wr),
    .m_q(m_q), .m_wait(m_wait)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Store model: wait cycles counted per access; stuck forces a permanent stall.
  logic [15:0] smem [512];
  bit          stuck = 1'b0;
  bit          rand_en = 1'b0;
  int          fixed_wait = 0;
  int          rnd_wait = 0;
  int          cnt = 0;
  int          cur_wait;

  assign cur_wait = rand_en ? rnd_wait : fixed_wait;
  assign m_wait   = stuck || (cnt < cur_wait);

  always @(posedge clk) begin
    if (!rst_n || !(m_rd || m_wr)) begin
      cnt <= 0;
    end else if (m_wait) begin
      cnt <= cnt + 1;
    end else begin
      cnt      <= 0;
      rnd_wait <= int'($urandom_range(0, 3));
      if (m_wr) smem[m_addr] <= m_d;
      else      m_q <= smem[m_addr];
    end
  end

  // Reference model: what the store should hold after every completed write.
  logic [15:0] ref_mem [512];
  bit          ref_valid [512];

  typedef struct {
    bit          we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          chk_data;
    bit          err;
    int          strobes;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  bit   ack_log[$];

  task automatic do_op(input bit port, input bit we, input logic [8:0] addr,
                       input logic [15:0] wd, input bit abort_exp,
                       input int strobes, input int lat);
    rec_t r;
    int   n;
    bit   got;
    r.we = we; r.addr = addr; r.wdata = wd; r.err = abort_exp; r.strobes = strobes;
    if (abort_exp) begin
      r.rdata = 16'h0000; r.chk_data = !we;
    end else if (we) begin
      ref_mem[addr] = wd; ref_valid[addr] = 1'b1;
      r.rdata = 16'h0000; r.chk_data = 1'b0;
    end else begin
      r.rdata = ref_mem[addr]; r.chk_data = ref_valid[addr];
    end
    @(posedge clk); #1;
    if (port) begin
      qb.push_back(r);
      b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
    end else begin
      qa.push_back(r);
      a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    end
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk);
      got = port ? b_ack : a_ack;
    end
    if (port) b_req = 1'b0; else a_req = 1'b0;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL ack_timeout: port %0d got no ack expected ack within 200 cycles", port);
    end else if (lat >= 0) begin
      check(port ? "b_latency" : "a_latency", 32'(n), 32'(lat));
    end
  endtask

  // Monitor: pops the expected record on every ack and checks the access seen on the store.
  int          stb_cnt = 0;
  logic [8:0]  stb_addr = '0;
  logic [15:0] stb_d = '0;
  bit          stb_we = 1'b0;

  initial begin
    rec_t r;
    bit   p;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stb_cnt = 0;
      end else begin
        if (m_rd || m_wr) begin
          stb_cnt++;
          stb_addr = m_addr; stb_d = m_d; stb_we = m_wr;
          check("strobes_exclusive", {31'd0, m_rd && m_wr}, 32'd0);
          check("strobe_needs_req", {31'd0, a_req || b_req}, 32'd1);
        end
        if (err && !(a_ack || b_ack)) check("err_without_ack", {31'd0, err}, 32'd0);
        if (a_ack || b_ack) begin
          check("single_ack", {31'd0, a_ack && b_ack}, 32'd0);
          check("strobe_in_ack", {31'd0, m_rd || m_wr}, 32'd0);
          p = b_ack;
          if ((p && qb.size() == 0) || (!p && qa.size() == 0)) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_ack: port %0d acked with no pending request", p);
          end else begin
            r = p ? qb.pop_front() : qa.pop_front();
            ack_log.push_back(p);
            check("err", {31'd0, err}, {31'd0, r.err});
            if (r.chk_data) check("rdata", p ? b_rdata : a_rdata, {16'd0, r.rdata});
            check("other_rdata", p ? a_rdata : b_rdata, 32'd0);
            if (r.strobes >= 0) check("strobe_cycles", 32'(stb_cnt), 32'(r.strobes));
            check("m_addr", {23'd0, stb_addr}, {23'd0, r.addr});
            check("m_we", {31'd0, stb_we}, {31'd0, r.we});
            if (r.we) check("m_d", {16'd0, stb_d}, {16'd0, r.wdata});
          end
          stb_cnt = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a_ack", {31'd0, a_ack}, 32'd0);
    check("reset_b_ack", {31'd0, b_ack}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_strobes", {30'd0, m_rd, m_wr}, 32'd0);
    check("reset_m_addr", {23'd0, m_addr}, 32'd0);
    rst_n = 1'b1;

    // Simultaneous requests after reset: A first, then strict alternation.
    fork
      begin
        do_op(0, 0, 9'd30, 16'h0, 0, 1, -1);
        for (int i = 0; i < 3; i++) do_op(0, 1, 9'd30, 16'(16'h1100 + i), 0, 1, -1);
      end
      begin
        do_op(1, 0, 9'd31, 16'h0, 0, 1, -1);
        for (int i = 0; i < 3; i++) do_op(1, 1, 9'd31, 16'(16'h2200 + i), 0, 1, -1);
      end
    join
    check("rr_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < ack_log.size(); i++) check("rr_order", {31'd0, ack_log[i]}, 32'(i % 2));
    ack_log.delete();

    // Plain write then read-back, no stall.
    do_op(0, 1, 9'd37, 16'h5A1E, 0, 1, 2);
    do_op(0, 0, 9'd37, 16'h0, 0, 1, 2);

    // Three stall cycles.
    fixed_wait = 3;
    do_op(0, 0, 9'd37, 16'h0, 0, 4, 5);
    fixed_wait = 0;

    // Stuck store: read and write both time out; aborted write leaves the word intact.
    stuck = 1'b1;
    do_op(0, 0, 9'd37, 16'h0, 1, TIMEOUT, TIMEOUT + 1);
    do_op(1, 1, 9'd37, 16'hFFFF, 1, TIMEOUT, TIMEOUT + 1);
    stuck = 1'b0;
    do_op(0, 0, 9'd37, 16'h0, 0, 1, 2);

    // Reset during a stalled write.
    do_op(0, 1, 9'd40, 16'h1234, 0, 1, 2);
    stuck = 1'b1;
    @(posedge clk); #1;
    a_we = 1'b1; a_addr = 9'd40; a_wdata = 16'hDEAD; a_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wr_before_reset", {31'd0, m_wr}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_m_wr", {31'd0, m_wr}, 32'd0);
    check("async_m_rd", {31'd0, m_rd}, 32'd0);
    check("async_acks", {30'd0, a_ack, b_ack}, 32'd0);
    check("async_err", {31'd0, err}, 32'd0);
    a_req = 1'b0; stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(0, 0, 9'd40, 16'h0, 0, 1, 2);

    // B reaches the top word while A keeps requesting.
    fork
      for (int i = 0; i < 4; i++) do_op(0, 1, 9'd5, 16'(16'h0500 + i), 0, 1, -1);
      begin
        do_op(1, 1, 9'h1FF, 16'hBEEF, 0, 1, -1);
        do_op(1, 0, 9'h1FF, 16'h0, 0, 1, -1);
      end
    join
    ack_log.delete();

    // Random traffic with random store stalls on disjoint address windows.
    rand_en = 1'b1;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_op(0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 16'($urandom), 0, -1, -1);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_op(1, 1'($urandom_range(0, 1)), 9'(256 + $urandom_range(0, 15)), 16'($urandom), 0, -1, -1);
      end
    join
    rand_en = 1'b0;

    repeat (5) @(posedge clk);
    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
